// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-requester round-robin arbiter onto one memory port
// One transaction in flight: IDLE picks an owner, REQ forwards its request, RSP returns the response.
module mem_port_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req_vld,
    output logic            m0_req_rdy,
    input  logic [AW-1:0]   m0_req_addr,
    input  logic [DW/8-1:0] m0_req_wstrb,
    input  logic [DW-1:0]   m0_req_wdata,
    output logic            m0_rsp_vld,
    input  logic            m0_rsp_rdy,
    output logic [DW-1:0]   m0_rsp_rdata,
    input  logic            m1_req_vld,
    output logic            m1_req_rdy,
    input  logic [AW-1:0]   m1_req_addr,
    input  logic [DW/8-1:0] m1_req_wstrb,
    input  logic [DW-1:0]   m1_req_wdata,
    output logic            m1_rsp_vld,
    input  logic            m1_rsp_rdy,
    output logic [DW-1:0]   m1_rsp_rdata,
    output logic            mem_req_vld,
    input  logic            mem_req_rdy,
    output logic [AW-1:0]   mem_req_addr,
    output logic [DW/8-1:0] mem_req_wstrb,
    output logic [DW-1:0]   mem_req_wdata,
    input  logic            mem_rsp_vld,
    output logic            mem_rsp_rdy,
    input  logic [DW-1:0]   mem_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last_gnt, last_gnt_nxt;
    logic   owner_rsp_rdy;

    assign owner_rsp_rdy = owner ? m1_rsp_rdy : m0_rsp_rdy;

    // Read data is qualified by the per-requester rsp_vld, so it can fan out to both.
    assign m0_rsp_rdata = mem_rsp_rdata;
    assign m1_rsp_rdata = mem_rsp_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        last_gnt_nxt  = last_gnt;
        m0_req_rdy    = 1'b0;
        m1_req_rdy    = 1'b0;
        m0_rsp_vld    = 1'b0;
        m1_rsp_vld    = 1'b0;
        mem_req_vld   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wstrb = '0;
        mem_req_wdata = '0;
        mem_rsp_rdy   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req_vld || m1_req_vld) begin
                    // Under contention the requester not served last time wins.
                    owner_nxt = (m0_req_vld && m1_req_vld) ? ~last_gnt : m1_req_vld;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_vld   = 1'b1;
                mem_req_addr  = owner ? m1_req_addr  : m0_req_addr;
                mem_req_wstrb = owner ? m1_req_wstrb : m0_req_wstrb;
                mem_req_wdata = owner ? m1_req_wdata : m0_req_wdata;
                m0_req_rdy    = ~owner & mem_req_rdy;
                m1_req_rdy    = owner & mem_req_rdy;
                if (mem_req_rdy) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                mem_rsp_rdy = owner_rsp_rdy;
                m0_rsp_vld  = ~owner & mem_rsp_vld;
                m1_rsp_vld  = owner & mem_rsp_vld;
                if (mem_rsp_vld && owner_rsp_rdy) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - self-checking bench for mem_port_arb
// Directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arb;

    logic        clk;
    logic        rst;
    logic        m0_req_vld, m0_req_rdy, m0_rsp_vld, m0_rsp_rdy;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic [3:0]  m0_req_wstrb;
    logic        m1_req_vld, m1_req_rdy, m1_rsp_vld, m1_rsp_rdy;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [3:0]  m1_req_wstrb;
    logic        mem_req_vld, mem_req_rdy, mem_rsp_vld, mem_rsp_rdy;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [3:0]  mem_req_wstrb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_model [logic [31:0]];

    mem_port_arb #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req_vld(m0_req_vld), .m0_req_rdy(m0_req_rdy), .m0_req_addr(m0_req_addr),
        .m0_req_wstrb(m0_req_wstrb), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_vld(m1_req_vld), .m1_req_rdy(m1_req_rdy), .m1_req_addr(m1_req_addr),
        .m1_req_wstrb(m1_req_wstrb), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_rdata(m1_rsp_rdata),
        .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_vld(mem_rsp_vld), .mem_rsp_rdy(mem_rsp_rdy), .mem_rsp_rdata(mem_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req_vld = 0; m0_req_addr = 0; m0_req_wstrb = 0; m0_req_wdata = 0; m0_rsp_rdy = 0;
        m1_req_vld = 0; m1_req_addr = 0; m1_req_wstrb = 0; m1_req_wdata = 0; m1_rsp_rdy = 0;
        mem_req_rdy = 0; mem_rsp_vld = 0; mem_rsp_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    function automatic logic [31:0] read_model(input logic [31:0] addr);
        return mem_model.exists(addr) ? mem_model[addr] : ~addr;
    endfunction

    // Drives a grant attempt to completion; reports the winner and cycles until mem_req_vld.
    task automatic run_grant(input logic v0, input logic v1, output int who, output int lat);
        who = -1;
        lat = 0;
        m0_req_vld = v0; m0_req_addr = 32'h40;
        m1_req_vld = v1; m1_req_addr = 32'h80;
        mem_req_rdy = 1; mem_rsp_vld = 1; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
        for (int i = 1; i <= 8 && who == -1; i++) begin
            tick();
            if (mem_req_vld) begin
                lat = i;
                who = m1_req_rdy ? 1 : (m0_req_rdy ? 0 : -2);
            end
        end
        if (who >= 0) begin
            tick();
            if (who == 0) m0_req_vld = 0;
            else m1_req_vld = 0;
            tick();
        end
        mem_rsp_vld = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        m0_req_vld = 1; mem_rsp_vld = 1; m0_rsp_rdy = 1; mem_req_rdy = 1;
        rst = 1;
        tick();
        checks++; if (mem_req_vld !== 1'b0) begin failures++; $display("FAIL rst_mem_req_vld got=%b exp=0", mem_req_vld); end
        checks++; if ({m1_req_rdy, m0_req_rdy} !== 2'b00) begin failures++; $display("FAIL rst_req_rdy got=%b exp=00", {m1_req_rdy, m0_req_rdy}); end
        checks++; if ({m1_rsp_vld, m0_rsp_vld} !== 2'b00) begin failures++; $display("FAIL rst_rsp_vld got=%b exp=00", {m1_rsp_vld, m0_rsp_vld}); end
        checks++; if (mem_rsp_rdy !== 1'b0) begin failures++; $display("FAIL rst_mem_rsp_rdy got=%b exp=0", mem_rsp_rdy); end
        checks++; if (mem_req_wstrb !== 4'h0) begin failures++; $display("FAIL rst_wstrb got=%h exp=0", mem_req_wstrb); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req_vld = 1; m0_req_addr = 32'h100; m0_req_wstrb = 0; m0_req_wdata = 32'hFFFF_FFFF;
        mem_req_rdy = 1;
        #1;
        checks++; if (mem_req_vld !== 1'b0) begin failures++; $display("FAIL sr_idle_vld got=%b exp=0", mem_req_vld); end
        tick();
        checks++; if (mem_req_vld !== 1'b1) begin failures++; $display("FAIL sr_req_vld got=%b exp=1", mem_req_vld); end
        checks++; if (mem_req_addr !== 32'h100) begin failures++; $display("FAIL sr_addr got=%h exp=100", mem_req_addr); end
        checks++; if (mem_req_wstrb !== 4'h0) begin failures++; $display("FAIL sr_wstrb got=%h exp=0", mem_req_wstrb); end
        checks++; if ({m1_req_rdy, m0_req_rdy} !== 2'b01) begin failures++; $display("FAIL sr_req_rdy got=%b exp=01", {m1_req_rdy, m0_req_rdy}); end
        tick();
        m0_req_vld = 0; mem_req_rdy = 0;
        mem_rsp_vld = 1; mem_rsp_rdata = 32'hDEAD_BEEF; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
        #1;
        checks++; if ({m1_rsp_vld, m0_rsp_vld} !== 2'b01) begin failures++; $display("FAIL sr_rsp_vld got=%b exp=01", {m1_rsp_vld, m0_rsp_vld}); end
        checks++; if (m0_rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sr_rdata got=%h exp=deadbeef", m0_rsp_rdata); end
        checks++; if (mem_rsp_rdy !== 1'b1) begin failures++; $display("FAIL sr_mem_rsp_rdy got=%b exp=1", mem_rsp_rdy); end
        tick();
        mem_rsp_vld = 0; m0_rsp_rdy = 0;
        #1;
        checks++; if ({mem_req_vld, m0_rsp_vld} !== 2'b00) begin failures++; $display("FAIL sr_done got=%b exp=00", {mem_req_vld, m0_rsp_vld}); end
    endtask

    task automatic test_contention();
        int who, lat;
        do_reset();
        run_grant(1, 1, who, lat);
        checks++; if (who !== 0) begin failures++; $display("FAIL ct_first got=%0d exp=0", who); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL ct_first_lat got=%0d exp=1", lat); end
        run_grant(0, 1, who, lat);
        checks++; if (who !== 1) begin failures++; $display("FAIL ct_second got=%0d exp=1", who); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL ct_second_lat got=%0d exp=1", lat); end
        run_grant(1, 1, who, lat);
        checks++; if (who !== 0) begin failures++; $display("FAIL ct_third got=%0d exp=0", who); end
        run_grant(0, 1, who, lat);
        checks++; if (who !== 1) begin failures++; $display("FAIL ct_fourth got=%0d exp=1", who); end
    endtask

    task automatic test_write_stall();
        do_reset();
        m1_req_vld = 1; m1_req_addr = 32'h200; m1_req_wstrb = 4'hF; m1_req_wdata = 32'h1234_5678;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                m0_req_vld = 1; m0_req_addr = 32'h400;
                #1;
            end
            checks++; if (mem_req_vld !== 1'b1) begin failures++; $display("FAIL ws_vld[%0d] got=%b exp=1", i, mem_req_vld); end
            checks++;
            if ({mem_req_addr, mem_req_wstrb, mem_req_wdata} !== {32'h200, 4'hF, 32'h1234_5678}) begin
                failures++; $display("FAIL ws_payload[%0d] got=%h/%h/%h exp=200/f/12345678", i, mem_req_addr, mem_req_wstrb, mem_req_wdata);
            end
            checks++; if ({m1_req_rdy, m0_req_rdy} !== 2'b00) begin failures++; $display("FAIL ws_stall_rdy[%0d] got=%b exp=00", i, {m1_req_rdy, m0_req_rdy}); end
            tick();
        end
        mem_req_rdy = 1;
        #1;
        checks++; if ({m1_req_rdy, m0_req_rdy} !== 2'b10) begin failures++; $display("FAIL ws_accept_rdy got=%b exp=10", {m1_req_rdy, m0_req_rdy}); end
        tick();
        m1_req_vld = 0; mem_req_rdy = 0; mem_rsp_vld = 1; m1_rsp_rdy = 1;
        #1;
        checks++; if ({mem_req_vld, m1_req_rdy, m0_req_rdy} !== 3'b000) begin failures++; $display("FAIL ws_rsp_req got=%b exp=000", {mem_req_vld, m1_req_rdy, m0_req_rdy}); end
        checks++; if ({m1_rsp_vld, m0_rsp_vld} !== 2'b10) begin failures++; $display("FAIL ws_rsp_vld got=%b exp=10", {m1_rsp_vld, m0_rsp_vld}); end
        tick();
        mem_rsp_vld = 0; m1_rsp_rdy = 0;
        #1;
        checks++; if (mem_req_vld !== 1'b0) begin failures++; $display("FAIL ws_idle_vld got=%b exp=0", mem_req_vld); end
        tick();
        checks++; if ({mem_req_vld, mem_req_addr} !== {1'b1, 32'h400}) begin failures++; $display("FAIL ws_m0_grant got=%b/%h exp=1/400", mem_req_vld, mem_req_addr); end
    endtask

    task automatic test_rsp_backpressure();
        do_reset();
        m0_req_vld = 1; m0_req_addr = 32'h300; mem_req_rdy = 1;
        tick();
        tick();
        m0_req_vld = 0; mem_req_rdy = 0;
        mem_rsp_vld = 1; mem_rsp_rdata = 32'hA5A5_5A5A; m0_rsp_rdy = 0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_rsp_rdy !== 1'b0) begin failures++; $display("FAIL bp_rdy[%0d] got=%b exp=0", i, mem_rsp_rdy); end
            checks++; if (m0_rsp_vld !== 1'b1) begin failures++; $display("FAIL bp_vld[%0d] got=%b exp=1", i, m0_rsp_vld); end
            tick();
        end
        m0_rsp_rdy = 1;
        #1;
        checks++; if (mem_rsp_rdy !== 1'b1) begin failures++; $display("FAIL bp_release got=%b exp=1", mem_rsp_rdy); end
        checks++; if (m0_rsp_rdata !== 32'hA5A5_5A5A) begin failures++; $display("FAIL bp_rdata got=%h exp=a5a55a5a", m0_rsp_rdata); end
        tick();
        checks++; if ({m0_rsp_vld, mem_rsp_rdy} !== 2'b00) begin failures++; $display("FAIL bp_after got=%b exp=00", {m0_rsp_vld, mem_rsp_rdy}); end
        mem_rsp_vld = 0;
    endtask

    task automatic test_reset_mid_rsp();
        int who, lat;
        do_reset();
        run_grant(1, 0, who, lat);
        checks++; if (who !== 0) begin failures++; $display("FAIL rm_pre got=%0d exp=0", who); end
        m1_req_vld = 1; m1_req_addr = 32'h500; mem_req_rdy = 1; m1_rsp_rdy = 0;
        tick();
        tick();
        m1_req_vld = 0; mem_req_rdy = 0; mem_rsp_vld = 1;
        #1;
        checks++; if (m1_rsp_vld !== 1'b1) begin failures++; $display("FAIL rm_in_rsp got=%b exp=1", m1_rsp_vld); end
        rst = 1;
        tick();
        rst = 0; m0_rsp_rdy = 1; m1_rsp_rdy = 1;
        #1;
        checks++; if ({m1_rsp_vld, m0_rsp_vld, mem_rsp_rdy} !== 3'b000) begin failures++; $display("FAIL rm_late_rsp got=%b exp=000", {m1_rsp_vld, m0_rsp_vld, mem_rsp_rdy}); end
        tick();
        checks++; if ({m1_rsp_vld, m0_rsp_vld, mem_rsp_rdy, mem_req_vld} !== 4'b0000) begin failures++; $display("FAIL rm_late_rsp2 got=%b exp=0000", {m1_rsp_vld, m0_rsp_vld, mem_rsp_rdy, mem_req_vld}); end
        run_grant(1, 1, who, lat);
        checks++; if (who !== 0) begin failures++; $display("FAIL rm_contention got=%0d exp=0", who); end
    endtask

    // Transaction-level model: phase 0 waiting for arbitration, 1 request forwarded, 2 response pending.
    task automatic test_random();
        int          ph, own, last, txns;
        logic        pend [2];
        logic        wait_rsp [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [3:0]  s [2];
        logic [31:0] exp_rd, old;
        logic [1:0]  exp_rdy, exp_vld;
        logic        own_rr;
        do_reset();
        ph = 0; own = 0; last = 1; txns = 0; exp_rd = 0;
        for (int i = 0; i < 2; i++) begin pend[i] = 0; wait_rsp[i] = 0; a[i] = 0; d[i] = 0; s[i] = 0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && !wait_rsp[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1;
                    a[i] = 32'(($urandom % 8) * 4);
                    s[i] = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
                    d[i] = $urandom;
                end
            end
            m0_req_vld = pend[0]; m0_req_addr = a[0]; m0_req_wstrb = s[0]; m0_req_wdata = d[0];
            m1_req_vld = pend[1]; m1_req_addr = a[1]; m1_req_wstrb = s[1]; m1_req_wdata = d[1];
            m0_rsp_rdy = 1'($urandom % 2); m1_rsp_rdy = 1'($urandom % 2);
            mem_req_rdy = 1'($urandom % 2); mem_rsp_vld = 1'($urandom % 2);
            mem_rsp_rdata = (ph == 2) ? exp_rd : $urandom;
            #1;
            own_rr  = own ? m1_rsp_rdy : m0_rsp_rdy;
            exp_rdy = (ph == 1 && mem_req_rdy) ? (own ? 2'b10 : 2'b01) : 2'b00;
            exp_vld = (ph == 2 && mem_rsp_vld) ? (own ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (mem_req_vld !== (ph == 1)) begin failures++; $display("FAIL rnd_req_vld cyc=%0d got=%b exp=%b", cyc, mem_req_vld, ph == 1); end
            checks++; if ({m1_req_rdy, m0_req_rdy} !== exp_rdy) begin failures++; $display("FAIL rnd_req_rdy cyc=%0d got=%b exp=%b", cyc, {m1_req_rdy, m0_req_rdy}, exp_rdy); end
            checks++;
            if (ph == 1) begin
                if ({mem_req_addr, mem_req_wstrb, mem_req_wdata} !== {a[own], s[own], d[own]}) begin
                    failures++; $display("FAIL rnd_payload cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, mem_req_addr, mem_req_wstrb, mem_req_wdata, a[own], s[own], d[own]);
                end
            end else if (mem_req_wstrb !== 4'h0) begin
                failures++; $display("FAIL rnd_wstrb cyc=%0d got=%h exp=0", cyc, mem_req_wstrb);
            end
            checks++; if ({m1_rsp_vld, m0_rsp_vld} !== exp_vld) begin failures++; $display("FAIL rnd_rsp_vld cyc=%0d got=%b exp=%b", cyc, {m1_rsp_vld, m0_rsp_vld}, exp_vld); end
            checks++; if (mem_rsp_rdy !== (ph == 2 && own_rr)) begin failures++; $display("FAIL rnd_rsp_rdy cyc=%0d got=%b exp=%b", cyc, mem_rsp_rdy, ph == 2 && own_rr); end
            if (ph == 2 && mem_rsp_vld) begin
                checks++;
                if ((own ? m1_rsp_rdata : m0_rsp_rdata) !== exp_rd) begin
                    failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, own ? m1_rsp_rdata : m0_rsp_rdata, exp_rd);
                end
            end
            if (ph == 0) begin
                if (pend[0] || pend[1]) begin
                    own = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (mem_req_rdy) begin
                    ph = 2; pend[own] = 0; wait_rsp[own] = 1;
                    if (s[own] == 4'h0) begin
                        exp_rd = read_model(a[own]);
                    end else begin
                        old = read_model(a[own]);
                        for (int b = 0; b < 4; b++) if (s[own][b]) old[8*b +: 8] = d[own][8*b +: 8];
                        mem_model[a[own]] = old;
                        exp_rd = $urandom;
                    end
                end
            end else if (mem_rsp_vld && own_rr) begin
                ph = 0; wait_rsp[own] = 0; last = own; txns++;
            end
            tick();
        end
        checks++; if (txns < 20) begin failures++; $display("FAIL rnd_progress got=%0d exp>=20", txns); end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_write_stall();
        test_rsp_backpressure();
        test_reset_mid_rsp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits; DW SHALL be a multiple of 8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 mN_req_vld  input  1  request valid from requester N (N=0 fetch, N=1 load/store).
REQ-006 mN_req_rdy  output  1  request accepted from requester N.
REQ-007 mN_req_addr  input  AW  byte address from requester N.
REQ-008 mN_req_wstrb  input  DW/8  byte write strobes; all-zero means read.
REQ-009 mN_req_wdata  input  DW  write data from requester N.
REQ-010 mN_rsp_vld  output  1  response valid to requester N.
REQ-011 mN_rsp_rdy  input  1  requester N accepts the response.
REQ-012 mN_rsp_rdata  output  DW  read data to requester N.
REQ-013 mem_req_vld  output  1  request valid to the shared memory port.
REQ-014 mem_req_rdy  input  1  memory accepts the request.
REQ-015 mem_req_addr  output  AW  forwarded address.
REQ-016 mem_req_wstrb  output  DW/8  forwarded strobes.
REQ-017 mem_req_wdata  output  DW  forwarded write data.
REQ-018 mem_rsp_vld  input  1  memory response valid.
REQ-019 mem_rsp_rdy  output  1  arbiter accepts the memory response.
REQ-020 mem_rsp_rdata  input  DW  memory read data.

Function
REQ-021 FSM states: IDLE, REQ, RSP; exactly one transaction is outstanding at a time.
REQ-022 IDLE: if any mN_req_vld is high, the block registers owner and moves to REQ on the next edge; with none high, it stays in IDLE.
REQ-023 Owner selection: round-robin; if both requesters are valid, the one not equal to last_gnt wins; if one is valid, it wins.
REQ-024 REQ: mem_req_vld=1 and mem_req_* = owner's mN_req_*; owner's mN_req_rdy = mem_req_rdy; the non-owner's req_rdy = 0.
REQ-025 REQ -> RSP on the edge where mem_req_vld & mem_req_rdy.
REQ-026 RSP: mem_rsp_vld and mem_rsp_rdata route to the owner's mN_rsp_*; mem_rsp_rdy = owner's mN_rsp_rdy; the non-owner's rsp_vld = 0.
REQ-027 RSP -> IDLE on mem_rsp_vld & mem_rsp_rdy; last_gnt <= owner on the same edge.
REQ-028 Latency: request-valid to mem_req_vld is 1 cycle; response pass-through is combinational (0 cycles).
REQ-029 Requesters hold mN_req_vld and payload stable until mN_req_rdy; the arbiter never changes owner while in REQ or RSP.
REQ-030 In IDLE and REQ: mem_rsp_rdy=0 and all mN_rsp_vld=0; a stray mem_rsp_vld is not forwarded.
REQ-031 Outside REQ: mem_req_vld=0 and all mN_req_rdy=0; mem_req_addr, mem_req_wstrb and mem_req_wdata are don't-care except that mem_req_wstrb is driven 0.
REQ-032 A new request from the same requester arriving in the IDLE cycle after RSP is arbitrated normally; there is no back-to-back bypass.

Reset
REQ-033 While rst=1 at a clock edge: state <= IDLE, last_gnt <= 1 (requester 0 wins the first contention), owner <= 0; all vld/rdy outputs SHALL be 0 from the following cycle.
REQ-034 Reset asserted mid-transaction (REQ or RSP) abandons the transaction; a late mem_rsp_vld after reset is ignored per REQ-030.

Verification
REQ-035 Reset, then m0 read addr 0x100: mem_req_vld rises 1 cycle later with addr 0x100 and wstrb 0; mem_rsp_rdata 0xDEADBEEF returns on m0_rsp_rdata only.
REQ-036 m0 and m1 valid in the same cycle after reset: m0 is granted first; m1 is granted in the next IDLE; a third contention grants m0.
REQ-037 m1 write addr 0x200, wstrb 0xF, wdata 0x12345678, with mem_req_rdy held low for 5 cycles: payload stays stable, m1_req_rdy pulses only on the accept cycle, and m0_req_vld raised meanwhile is not granted.
REQ-038 m0_rsp_rdy held low for 3 cycles in RSP: mem_rsp_rdy=0 for those 3 cycles, and the FSM stays in RSP until the handshake.
REQ-039 rst pulsed during RSP, then mem_rsp_vld=1: no mN_rsp_vld is asserted, mem_rsp_rdy=0, and the next contention grants m0.
